// File: rtl/ms_dbio_hub_if.sv
// -----------------------------------------------------------------------------
// ms_dbio_hub_if
// Shared 64-bit memory port driven by the debug-I/O hub arbiter.
//   AMemAccess  : 1 while any group holds the grant
//   AMemAddr    : granted group's address [31:3], 0 when idle
//   AMemMosi    : granted group's write data, 0 when idle
//   AMemWrRdEn  : granted group's {write, read} enables, 0 when idle
// Modports: master (hub side, drives), slave (memory side, observes).
// -----------------------------------------------------------------------------
interface ms_dbio_hub_if;
   logic        AMemAccess;
   logic [28:0] AMemAddr;
   logic [63:0] AMemMosi;
   logic [1:0]  AMemWrRdEn;

   modport master (output AMemAccess, output AMemAddr, output AMemMosi, output AMemWrRdEn);
   modport slave  (input  AMemAccess, input  AMemAddr, input  AMemMosi, input  AMemWrRdEn);
endinterface

// File: rtl/ms_dbio_hub.sv
// -----------------------------------------------------------------------------
// ms_dbio_hub
// Debug-I/O fan-out hub: picks the Dbio master (boot FSM, then host, one-way),
// decodes Addr[11:8] into CGrpCnt functional groups, gates per-group strobes,
// indices and lengths, merges read data, and round-robin arbitrates the shared
// memory port among the groups with a bounded hold time.
//
// Ports:
//   AClkH / AResetHN / AClkHEn   clock, synchronous active-low reset, enable
//   AFsm* / AHost*               Dbio address, data, indices, strobes per master
//   AHostDataLen                 host transfer length
//   AGrp*  (out)                 broadcast addr/data, per-group gated signals
//   AGrpMiso / AGrpIdxReset      per-group read data and index-reset requests
//   ADbioMiso / ADbioIdxReset    merged read data and index reset
//   AAddrErr                     one-cycle pulse on an unmatched strobed address
//   AMasterHost                  0 = FSM master, 1 = host master
//   AGrpMem* (in) / AGrpMemGnt   per-group memory requests and one-hot grant
//   mem                          shared memory port (ms_dbio_hub_if.master)
//   AHoldOvf                     one-cycle pulse on a forced grant rotation
// -----------------------------------------------------------------------------
module ms_dbio_hub #(
   parameter int                   CGrpCnt  = 4,
   parameter logic [4*CGrpCnt-1:0] CGrpSel  = {4'h7, 4'h2, 4'h1, 4'h0},
   parameter int                   CHoldMax = 16
) (
   input  logic                    AClkH,
   input  logic                    AResetHN,
   input  logic                    AClkHEn,
   input  logic                    AFsmReady,
   input  logic [11:0]             AFsmAddr,
   input  logic [11:0]             AHostAddr,
   input  logic [63:0]             AFsmMosi,
   input  logic [63:0]             AHostMosi,
   input  logic [3:0]              AFsmMosiIdx,
   input  logic [3:0]              AHostMosiIdx,
   input  logic [3:0]              AFsmMisoIdx,
   input  logic [3:0]              AHostMisoIdx,
   input  logic                    AFsmMosi1st,
   input  logic                    AHostMosi1st,
   input  logic                    AFsmMiso1st,
   input  logic                    AHostMiso1st,
   input  logic [15:0]             AHostDataLen,
   output logic [7:0]              AGrpAddr,
   output logic [63:0]             AGrpMosi,
   output logic [4*CGrpCnt-1:0]    AGrpMosiIdx,
   output logic [4*CGrpCnt-1:0]    AGrpMisoIdx,
   output logic [CGrpCnt-1:0]      AGrpMosi1st,
   output logic [CGrpCnt-1:0]      AGrpMiso1st,
   output logic [16*CGrpCnt-1:0]   AGrpDataLen,
   output logic [CGrpCnt-1:0]      AGrpDataLenNZ,
   input  logic [64*CGrpCnt-1:0]   AGrpMiso,
   input  logic [CGrpCnt-1:0]      AGrpIdxReset,
   output logic [63:0]             ADbioMiso,
   output logic                    ADbioIdxReset,
   output logic                    AAddrErr,
   output logic                    AMasterHost,
   input  logic [CGrpCnt-1:0]      AGrpMemReq,
   input  logic [29*CGrpCnt-1:0]   AGrpMemAddr,
   input  logic [64*CGrpCnt-1:0]   AGrpMemMosi,
   input  logic [2*CGrpCnt-1:0]    AGrpMemWrRdEn,
   output logic [CGrpCnt-1:0]      AGrpMemGnt,
   ms_dbio_hub_if.master           mem,
   output logic                    AHoldOvf
);

   localparam int         CIdxW     = (CGrpCnt > 1) ? $clog2(CGrpCnt) : 1;
   localparam logic [7:0] CHoldLast = 8'(CHoldMax - 1);

   typedef enum logic {MST_FSM = 1'b0, MST_HOST = 1'b1} master_e;

   // ---------------------------------------------------------------- registers
   master_e              r_master;
   logic                 r_addr_err;
   logic                 r_hold_ovf;
   logic [CGrpCnt-1:0]   r_gnt;
   logic [CIdxW-1:0]     r_ptr;
   logic [7:0]           r_hold_cnt;

   // ---------------------------------------------------------------- wires
   logic                 w_host;
   logic [11:0]          w_addr;
   logic [63:0]          w_mosi;
   logic [3:0]           w_mosi_idx;
   logic [3:0]           w_miso_idx;
   logic                 w_mosi1st;
   logic                 w_miso1st;
   logic [CGrpCnt-1:0]   w_cs;
   logic                 w_cs_any;
   logic [CIdxW-1:0]     w_hold_idx;
   logic [CIdxW:0]       w_idle_pick;   // {found, index}
   logic [CIdxW:0]       w_next_pick;   // {found, index}
   logic                 w_hold_req;
   logic                 w_others;
   logic                 w_hold_done;
   logic [28:0]          w_mem_addr;
   logic [63:0]          w_mem_mosi;
   logic [1:0]           w_mem_wrrd;

   // First requester at or after 'start' (modulo CGrpCnt); lowest offset wins.
   function automatic logic [CIdxW:0] f_rr_pick(input logic [CGrpCnt-1:0] req,
                                                 input int start);
      logic [CIdxW:0] res;
      res = '0;
      for (int off = CGrpCnt - 1; off >= 0; off--) begin
         int j;
         j = (start + off) % CGrpCnt;
         if (req[j]) res = {1'b1, CIdxW'(j)};
      end
      return res;
   endfunction

   function automatic logic [CIdxW-1:0] f_next_ptr(input logic [CIdxW-1:0] idx);
      return CIdxW'((int'(idx) + 1) % CGrpCnt);
   endfunction

   // ---------------------------------------------------------------- master mux
   assign w_host     = (r_master == MST_HOST);
   assign w_addr     = w_host ? AHostAddr    : AFsmAddr;
   assign w_mosi     = w_host ? AHostMosi    : AFsmMosi;
   assign w_mosi_idx = w_host ? AHostMosiIdx : AFsmMosiIdx;
   assign w_miso_idx = w_host ? AHostMisoIdx : AFsmMisoIdx;
   assign w_mosi1st  = w_host ? AHostMosi1st : AFsmMosi1st;
   assign w_miso1st  = w_host ? AHostMiso1st : AFsmMiso1st;

   // ---------------------------------------------------------------- decode
   // Duplicate group codes resolve to the lowest matching index only.
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_cs     = '0;
      w_cs_any = 1'b0;
      for (int i = 0; i < CGrpCnt; i++) begin
         if (!w_cs_any && (w_addr[11:8] == CGrpSel[4*i +: 4])) begin
            w_cs[i]  = 1'b1;
            w_cs_any = 1'b1;
         end
      end
   end

   assign AGrpAddr      = w_addr[7:0];
   assign AGrpMosi      = w_mosi;
   assign ADbioIdxReset = |AGrpIdxReset;
   assign AAddrErr      = r_addr_err;
   assign AMasterHost   = w_host;

   always_comb begin
      AGrpMosiIdx   = '0;
      AGrpMisoIdx   = '0;
      AGrpMosi1st   = '0;
      AGrpMiso1st   = '0;
      AGrpDataLen   = '0;
      AGrpDataLenNZ = '0;
      ADbioMiso     = '0;
      for (int i = 0; i < CGrpCnt; i++) begin
         if (w_cs[i]) begin
            AGrpMosiIdx[4*i +: 4] = w_mosi_idx;
            AGrpMisoIdx[4*i +: 4] = w_miso_idx;
            AGrpMosi1st[i]        = w_mosi1st;
            AGrpMiso1st[i]        = w_miso1st;
            ADbioMiso             = ADbioMiso | AGrpMiso[64*i +: 64];
            if (w_host) begin
               AGrpDataLen[16*i +: 16] = AHostDataLen;
               AGrpDataLenNZ[i]        = (AHostDataLen != 16'h0);
            end
         end
      end
   end

   // ---------------------------------------------------------------- arbiter
   always_comb begin
      w_hold_idx = '0;
      for (int i = 0; i < CGrpCnt; i++) begin
         if (r_gnt[i]) w_hold_idx = CIdxW'(i);
      end
   end

   assign w_idle_pick = f_rr_pick(AGrpMemReq, int'(r_ptr));
   // The holder's own bit is masked, so only other requesters are candidates.
   assign w_next_pick = f_rr_pick(AGrpMemReq & ~r_gnt, int'(w_hold_idx) + 1);
   assign w_hold_req  = |(AGrpMemReq & r_gnt);
   assign w_others    = |(AGrpMemReq & ~r_gnt);
   assign w_hold_done = (r_hold_cnt == CHoldLast);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge AClkH) begin
      if (!AResetHN) begin
         r_master   <= MST_FSM;
         r_addr_err <= 1'b0;
         r_hold_ovf <= 1'b0;
         r_gnt      <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
      end else if (AClkHEn) begin
         // Handover waits for a quiet FSM bus so no transfer is split.
         if (r_master == MST_FSM && AFsmReady && !AFsmMosi1st && !AFsmMiso1st)
            r_master <= MST_HOST;

         r_addr_err <= (w_mosi1st | w_miso1st) & ~w_cs_any;
         r_hold_ovf <= 1'b0;

         if (r_gnt == '0) begin
            r_hold_cnt <= '0;
            if (w_idle_pick[CIdxW]) begin
               r_gnt <= CGrpCnt'(1) << w_idle_pick[CIdxW-1:0];
               r_ptr <= f_next_ptr(w_idle_pick[CIdxW-1:0]);
            end
         end else if (!w_hold_req) begin
            // Holder released: pass directly to the next waiter, or go idle.
            r_hold_cnt <= '0;
            if (w_next_pick[CIdxW]) begin
               r_gnt <= CGrpCnt'(1) << w_next_pick[CIdxW-1:0];
               r_ptr <= f_next_ptr(w_next_pick[CIdxW-1:0]);
            end else begin
               r_gnt <= '0;
            end
         end else if (w_hold_done && w_others) begin
            // Hold budget exhausted with someone waiting: forced rotation.
            r_hold_cnt <= '0;
            r_hold_ovf <= 1'b1;
            r_gnt      <= CGrpCnt'(1) << w_next_pick[CIdxW-1:0];
            r_ptr      <= f_next_ptr(w_next_pick[CIdxW-1:0]);
         end else if (!w_hold_done) begin
            // Saturating at CHoldMax-1 lets a late waiter rotate in at once.
            r_hold_cnt <= r_hold_cnt + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------- memory mux
   // Grant is one-hot, so an OR of the masked group fields is the mux.
   always_comb begin
      w_mem_addr = '0;
      w_mem_mosi = '0;
      w_mem_wrrd = '0;
      for (int i = 0; i < CGrpCnt; i++) begin
         if (r_gnt[i]) begin
            w_mem_addr = w_mem_addr | AGrpMemAddr[29*i +: 29];
            w_mem_mosi = w_mem_mosi | AGrpMemMosi[64*i +: 64];
            w_mem_wrrd = w_mem_wrrd | AGrpMemWrRdEn[2*i +: 2];
         end
      end
   end

   assign AGrpMemGnt     = r_gnt;
   assign AHoldOvf       = r_hold_ovf;
   assign mem.AMemAccess = |r_gnt;
   assign mem.AMemAddr   = w_mem_addr;
   assign mem.AMemMosi   = w_mem_mosi;
   assign mem.AMemWrRdEn = w_mem_wrrd;

endmodule

// File: tb/tb_ms_dbio_hub.sv
// -----------------------------------------------------------------------------
// tb_ms_dbio_hub
// Directed stimulus for ms_dbio_hub (default parameters). The stimulus process
// queues expected values tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_ms_dbio_hub;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clk_en;
   logic            fsm_ready;
   logic [11:0]     fsm_addr, host_addr;
   logic [63:0]     fsm_mosi, host_mosi;
   logic [3:0]      fsm_mosi_idx, host_mosi_idx, fsm_miso_idx, host_miso_idx;
   logic            fsm_mosi1st, host_mosi1st, fsm_miso1st, host_miso1st;
   logic [15:0]     host_len;
   logic [7:0]      grp_addr;
   logic [63:0]     grp_mosi;
   logic [4*N-1:0]  grp_mosi_idx, grp_miso_idx;
   logic [N-1:0]    grp_mosi1st, grp_miso1st;
   logic [16*N-1:0] grp_len;
   logic [N-1:0]    grp_len_nz;
   logic [64*N-1:0] grp_miso;
   logic [N-1:0]    grp_idx_reset;
   logic [63:0]     dbio_miso;
   logic            dbio_idx_reset;
   logic            addr_err;
   logic            master_host;
   logic [N-1:0]    mem_req;
   logic [29*N-1:0] mem_addr;
   logic [64*N-1:0] mem_mosi;
   logic [2*N-1:0]  mem_wrrd;
   logic [N-1:0]    mem_gnt;
   logic            hold_ovf;

   ms_dbio_hub_if u_mem ();

   ms_dbio_hub u_dut (
      .AClkH         (clk),
      .AResetHN      (rst_n),
      .AClkHEn       (clk_en),
      .AFsmReady     (fsm_ready),
      .AFsmAddr      (fsm_addr),
      .AHostAddr     (host_addr),
      .AFsmMosi      (fsm_mosi),
      .AHostMosi     (host_mosi),
      .AFsmMosiIdx   (fsm_mosi_idx),
      .AHostMosiIdx  (host_mosi_idx),
      .AFsmMisoIdx   (fsm_miso_idx),
      .AHostMisoIdx  (host_miso_idx),
      .AFsmMosi1st   (fsm_mosi1st),
      .AHostMosi1st  (host_mosi1st),
      .AFsmMiso1st   (fsm_miso1st),
      .AHostMiso1st  (host_miso1st),
      .AHostDataLen  (host_len),
      .AGrpAddr      (grp_addr),
      .AGrpMosi      (grp_mosi),
      .AGrpMosiIdx   (grp_mosi_idx),
      .AGrpMisoIdx   (grp_miso_idx),
      .AGrpMosi1st   (grp_mosi1st),
      .AGrpMiso1st   (grp_miso1st),
      .AGrpDataLen   (grp_len),
      .AGrpDataLenNZ (grp_len_nz),
      .AGrpMiso      (grp_miso),
      .AGrpIdxReset  (grp_idx_reset),
      .ADbioMiso     (dbio_miso),
      .ADbioIdxReset (dbio_idx_reset),
      .AAddrErr      (addr_err),
      .AMasterHost   (master_host),
      .AGrpMemReq    (mem_req),
      .AGrpMemAddr   (mem_addr),
      .AGrpMemMosi   (mem_mosi),
      .AGrpMemWrRdEn (mem_wrrd),
      .AGrpMemGnt    (mem_gnt),
      .mem           (u_mem),
      .AHoldOvf      (hold_ovf)
   );

   always #5 clk = ~clk;

   typedef enum int {
      F_MASTER, F_ADDRERR, F_HOLDOVF, F_GNT, F_MEMACC, F_MEMADDR, F_MEMWRRD,
      F_MOSI1ST, F_MISO1ST, F_MOSIIDX, F_DLEN, F_DLENNZ, F_DBIOMISO, F_IDXRST
   } field_e;

   typedef struct {
      int          cyc;
      field_e      fld;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, want);
      end
   endtask

   function automatic logic [63:0] actual(input field_e f);
      case (f)
         F_MASTER:   return 64'(master_host);
         F_ADDRERR:  return 64'(addr_err);
         F_HOLDOVF:  return 64'(hold_ovf);
         F_GNT:      return 64'(mem_gnt);
         F_MEMACC:   return 64'(u_mem.AMemAccess);
         F_MEMADDR:  return 64'(u_mem.AMemAddr);
         F_MEMWRRD:  return 64'(u_mem.AMemWrRdEn);
         F_MOSI1ST:  return 64'(grp_mosi1st);
         F_MISO1ST:  return 64'(grp_miso1st);
         F_MOSIIDX:  return 64'(grp_mosi_idx);
         F_DLEN:     return grp_len;
         F_DLENNZ:   return 64'(grp_len_nz);
         F_DBIOMISO: return dbio_miso;
         F_IDXRST:   return 64'(dbio_idx_reset);
         default:    return '1;
      endcase
   endfunction

   // Queue an expectation for the falling edge 'off' cycles from now.
   task automatic expect_at(input int off, input field_e f, input logic [63:0] v);
      exp_t e;
      e.cyc = cyc + off;
      e.fld = f;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         check(e.fld.name(), actual(e.fld), e.val);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clk_en = 1'b1; fsm_ready = 1'b0;
      fsm_addr = '0; host_addr = '0; fsm_mosi = 64'hF5F5; host_mosi = 64'hA0A0;
      fsm_mosi_idx = '0; host_mosi_idx = '0; fsm_miso_idx = '0; host_miso_idx = '0;
      fsm_mosi1st = 1'b0; host_mosi1st = 1'b0; fsm_miso1st = 1'b0; host_miso1st = 1'b0;
      host_len = '0; grp_miso = '0; grp_idx_reset = '0; mem_req = '0;
      for (int i = 0; i < N; i++) begin
         mem_addr[29*i +: 29] = 29'h100 + 29'(i);
         mem_mosi[64*i +: 64] = 64'hA0 + 64'(i);
         mem_wrrd[2*i +: 2]   = 2'(i);
      end

      // Reset state
      tick(); tick();                                      // cyc 2
      expect_at(0, F_MASTER, 0);
      expect_at(0, F_GNT, 0);
      expect_at(0, F_MEMACC, 0);
      expect_at(0, F_ADDRERR, 0);
      expect_at(0, F_HOLDOVF, 0);

      // FSM master decode; host length must be ignored
      rst_n = 1'b1;
      fsm_addr = 12'h105; fsm_mosi1st = 1'b1; fsm_mosi_idx = 4'h5;
      host_addr = 12'h7AA; host_len = 16'h20;
      expect_at(0, F_MOSI1ST, 64'b0010);
      expect_at(0, F_MOSIIDX, 64'h0050);
      expect_at(0, F_DLEN, 0);
      expect_at(0, F_DLENNZ, 0);
      tick();                                              // cyc 3
      expect_at(0, F_MASTER, 0);

      // Handover blocked while the FSM strobes
      fsm_ready = 1'b1; fsm_mosi1st = 1'b0; fsm_miso1st = 1'b1;
      expect_at(0, F_MISO1ST, 64'b0010);
      repeat (3) begin
         tick();
         expect_at(0, F_MASTER, 0);
         expect_at(0, F_ADDRERR, 0);
      end                                                  // cyc 6
      fsm_miso1st = 1'b0;
      tick();                                              // cyc 7
      expect_at(0, F_MASTER, 1);
      expect_at(0, F_DLENNZ, 64'b1000);
      expect_at(0, F_DLEN, 64'h0020_0000_0000_0000);
      expect_at(0, F_MOSI1ST, 0);

      // Host stays master when FSM ready drops
      fsm_ready = 1'b0;
      tick();                                              // cyc 8
      expect_at(0, F_MASTER, 1);

      // Unmatched address with a strobe
      host_addr = 12'h3FF; host_miso1st = 1'b1;
      grp_miso = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      expect_at(0, F_DBIOMISO, 0);
      expect_at(0, F_MISO1ST, 0);
      expect_at(0, F_ADDRERR, 0);
      tick();                                              // cyc 9
      expect_at(0, F_ADDRERR, 1);
      host_miso1st = 1'b0; host_addr = 12'h2A0; grp_idx_reset = 4'b0100;
      expect_at(0, F_DBIOMISO, 64'h3333_3333_3333_3333);
      expect_at(0, F_IDXRST, 1);
      tick();                                              // cyc 10
      expect_at(0, F_ADDRERR, 0);
      grp_idx_reset = '0;

      // Arbiter: simultaneous requests 0 and 2, then release handover
      mem_req = 4'b0101;
      expect_at(0, F_GNT, 0);
      expect_at(0, F_MEMADDR, 0);
      tick();                                              // cyc 11
      expect_at(0, F_GNT, 64'b0001);
      expect_at(0, F_MEMACC, 1);
      expect_at(0, F_MEMADDR, 64'h100);
      mem_req = 4'b0100;
      tick();                                              // cyc 12
      expect_at(0, F_GNT, 64'b0100);
      expect_at(0, F_MEMADDR, 64'h102);
      expect_at(0, F_MEMWRRD, 64'b10);
      mem_req = 4'b0000;
      tick();                                              // cyc 13
      expect_at(0, F_GNT, 0);
      expect_at(0, F_MEMACC, 0);
      expect_at(0, F_MEMADDR, 0);

      // Hold limit: group 1 holds, group 3 waits
      mem_req = 4'b0010;
      tick();                                              // cyc 14
      mem_req = 4'b1010;
      for (int j = 0; j < 16; j++) begin
         expect_at(j, F_GNT, 64'b0010);
         expect_at(j, F_HOLDOVF, 0);
      end
      expect_at(16, F_GNT, 64'b1000);
      expect_at(16, F_HOLDOVF, 1);
      expect_at(16, F_MEMADDR, 64'h103);
      repeat (16) tick();                                  // cyc 30

      // Disabled edge stretches the overflow pulse
      clk_en = 1'b0;
      tick();                                              // cyc 31
      expect_at(0, F_HOLDOVF, 1);
      expect_at(0, F_GNT, 64'b1000);
      clk_en = 1'b1;
      tick();                                              // cyc 32
      expect_at(0, F_HOLDOVF, 0);
      expect_at(0, F_GNT, 64'b1000);

      // Reset mid-grant with the clock enable low
      clk_en = 1'b0;
      tick();                                              // cyc 33
      expect_at(0, F_GNT, 64'b1000);
      expect_at(0, F_MASTER, 1);
      rst_n = 1'b0;
      tick();                                              // cyc 34
      expect_at(0, F_GNT, 0);
      expect_at(0, F_MEMACC, 0);
      expect_at(0, F_MASTER, 0);
      expect_at(0, F_HOLDOVF, 0);

      rst_n = 1'b1; clk_en = 1'b1; mem_req = '0;
      tick(); tick(); tick();
      check("scoreboard_drained", 64'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ms_dbio_hub.md
Name: ms_dbio_hub

Overview:
- Parametrised successor to the fixed three-group debug-I/O fan-out in the debug bridge top level.
- Selects the Dbio master: the boot test FSM first, then the host bridge. The handover is registered and one-way until reset.
- Decodes the Dbio address into CGrpCnt functional groups and gates their strobes and indices per group.
- Arbitrates the shared 64-bit memory port among the groups with a registered round-robin arbiter and a bounded hold time.

Parameters:
- CGrpCnt, 4, number of functional groups (1..8).
- CGrpSel, {4'h7,4'h2,4'h1,4'h0}, packed 4-bit Addr[11:8] code per group; group i uses bits [4i+3:4i].
- CHoldMax, 16, maximum consecutive enabled cycles a group keeps the memory grant while others are waiting (2..255).

Ports:
- AClkH  in  1  clock
- AResetHN  in  1  synchronous reset, active low
- AClkHEn  in  1  clock enable; all state updates only when 1
- AFsmReady  in  1  boot test FSM finished; host may take over
- AFsmAddr/AHostAddr  in  12  Dbio address per master
- AFsmMosi/AHostMosi  in  64  Dbio write data per master
- AFsmMosiIdx/AHostMosiIdx, AFsmMisoIdx/AHostMisoIdx  in  4  byte indices per master
- AFsmMosi1st/AHostMosi1st, AFsmMiso1st/AHostMiso1st  in  1  first-byte strobes per master
- AHostDataLen  in  16  host transfer length
- AGrpAddr  out  8  selected Addr[7:0], broadcast to all groups
- AGrpMosi  out  64  selected Mosi, broadcast to all groups
- AGrpMosiIdx, AGrpMisoIdx  out  4*CGrpCnt  per-group index, 0 when group not selected
- AGrpMosi1st, AGrpMiso1st  out  CGrpCnt  per-group gated strobes
- AGrpDataLen  out  16*CGrpCnt  per-group length, 0 unless host master and group selected
- AGrpDataLenNZ  out  CGrpCnt  per-group nonzero-length flag
- AGrpMiso  in  64*CGrpCnt  group read data
- AGrpIdxReset  in  CGrpCnt  group index-reset requests
- ADbioMiso  out  64  OR of CS-gated AGrpMiso
- ADbioIdxReset  out  1  OR of AGrpIdxReset
- AAddrErr  out  1  one-cycle pulse on an unmatched address
- AMasterHost  out  1  0 = FSM master, 1 = host master
- AGrpMemReq  in  CGrpCnt  memory request per group
- AGrpMemAddr  in  29*CGrpCnt  memory address [31:3] per group
- AGrpMemMosi  in  64*CGrpCnt  memory write data per group
- AGrpMemWrRdEn  in  2*CGrpCnt  write/read enables per group
- AGrpMemGnt  out  CGrpCnt  one-hot grant, registered
- AMemAccess  out  1  OR of grants
- AMemAddr  out  29  granted group's address, 0 when idle
- AMemMosi  out  64  granted group's write data, 0 when idle
- AMemWrRdEn  out  2  granted group's enables, 0 when idle
- AHoldOvf  out  1  one-cycle pulse on forced rotation

Behaviour:
- Reset (AResetHN=0 at a clock edge, regardless of AClkHEn):
  - AMasterHost=0, all grants 0, round-robin pointer 0, AAddrErr=0, AHoldOvf=0, hold counter 0.
  - All combinational outputs follow from that state.
- Master handover:
  - AMasterHost goes 0->1 at the first enabled edge where AFsmReady=1, AFsmMosi1st=0 and AFsmMiso1st=0.
  - It stays 1 until reset; it never reverts, even if AFsmReady later drops.
  - While AMasterHost=0, host inputs are ignored and all AGrpDataLen/AGrpDataLenNZ are 0.
- Decode (combinational, on the selected master):
  - CS[i] = (Addr[11:8]==CGrpSel[i]).
  - Duplicate codes in CGrpSel: only the lowest index matches.
  - Unselected groups see idx=0, strobes=0, length=0.
  - AGrpDataLenNZ[i] = CS[i] & AMasterHost & (AHostDataLen!=0).
  - ADbioMiso is combinational, no added latency.
  - AAddrErr is registered: it is 1 for one enabled cycle after an enabled edge where (Mosi1st|Miso1st) was 1 and no CS matched.
- Memory arbiter:
  - A request sampled at enabled edge N gives the grant visible after edge N (latency 1).
  - While granted and AGrpMemReq stays 1, the grant is held. The hold counter increments each enabled cycle.
  - If the hold counter reaches CHoldMax-1 while another request is pending, the grant moves to the next requester: AHoldOvf pulses and the counter clears.
  - If the holder is alone, it holds indefinitely and the counter saturates.
  - When the holder drops req, the grant passes at the same edge to the next pending requester, searching from holder+1 modulo CGrpCnt. With none pending, all grants go to 0.
  - Idle arbitration searches from the pointer. The pointer is set to granted index+1 on each new grant.
  - A grant is dropped the edge after its request falls, even if no one else is waiting.
  - Memory outputs are a combinational mux of the granted group, all-zero when idle.
- AClkHEn=0: all registers hold; pulses stretch until the next enabled edge clears them.

Test Plan:
- Reset, AFsmReady=0, FSM Addr=12'h105 with Mosi1st=1 -> AGrpMosi1st=4'b0010, AGrpDataLen all 0, AMasterHost=0.
- AFsmReady=1 while AFsmMiso1st=1 for 3 cycles -> AMasterHost stays 0 during those cycles, rises on the first cycle with both FSM strobes low; host Addr=12'h7AA with DataLen=16'h20 -> AGrpDataLenNZ=4'b1000, length 0x20 on group 3.
- Host Addr=12'h3FF with Miso1st=1 -> AAddrErr=1 for exactly one cycle, ADbioMiso=0, no strobes.
- Requests 0 and 2 raised together from reset -> grant 0 after one cycle; release 0 -> grant 2 on the same edge; AMemAddr follows the granted group's address.
- Group 1 holds its request and group 3 requests, CHoldMax=16 -> group 1 granted exactly 16 cycles, then AHoldOvf pulses and the grant moves to group 3.
- Assert reset mid-grant with AClkHEn=0 -> all grants 0 and AMemAccess=0 after the edge, AMasterHost=0.
